// File: rtl/sprite_row_scheduler.sv
// sprite_row_scheduler
//   During horizontal blanking, walks the sprite slots in index order. For every slot that
//   covers the prepared line it fetches that slot's 64-bit pixel row from a shared sprite ROM
//   into a per-slot row buffer. While the line is displayed, it picks the lowest-index visible,
//   non-transparent sprite pixel for the current x.
//
// Ports
//   clk, rst           : rising-edge clock; synchronous active-low reset (rst = 0 resets)
//   line_start, line_y : one-cycle pulse at start of h-blank, and the line to prepare
//   slot_en/x/y/id     : live per-slot configuration, packed with slot 0 in the low bits
//   rom_req, rom_addr  : ROM read request and address {image id, row}, held until rom_ack
//   rom_ack, rom_data  : ROM completion strobe and 64-bit row (16 pixels x 4 bits, column 0 in MSBs)
//   display_on, x, y   : current beam position
//   pix_hit, pix_color : registered sprite pixel for the previous cycle's x
//   overrun            : one-cycle pulse when display starts before the fetch scan has finished

module sprite_row_scheduler #(
    parameter int unsigned n_slots = 4,
    parameter int unsigned w_x     = 10,
    parameter int unsigned w_y     = 9,
    parameter int unsigned w_id    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    line_start,
    input  logic [w_y-1:0]          line_y,
    input  logic [n_slots-1:0]      slot_en,
    input  logic [n_slots*w_x-1:0]  slot_x,
    input  logic [n_slots*w_y-1:0]  slot_y,
    input  logic [n_slots*w_id-1:0] slot_id,
    output logic                    rom_req,
    output logic [w_id+3:0]         rom_addr,
    input  logic                    rom_ack,
    input  logic [63:0]             rom_data,
    input  logic                    display_on,
    input  logic [w_x-1:0]          x,
    input  logic [w_y-1:0]          y,
    output logic                    pix_hit,
    output logic [3:0]              pix_color,
    output logic                    overrun
);

    localparam int unsigned w_s = (n_slots > 1) ? $clog2(n_slots) : 1;

    typedef enum logic [1:0] {StIdle, StCheck, StReq, StWait} state_e;

    state_e              state_q;
    logic [w_s-1:0]      slot_q;
    logic [w_y-1:0]      line_q;
    logic [n_slots-1:0]  active_q;
    logic                ovr_done_q;
    logic [63:0]         row_buf [n_slots];

    // The line is latched at line_start, so the live y position is not needed.
    logic unused_y;
    assign unused_y = ^y;

    // Scan compare for the slot under examination.
    logic [w_y-1:0]  cur_y;
    logic [w_y-1:0]  dy;
    logic [w_id-1:0] cur_id;
    logic            cur_hit;
    logic            last_slot;
    logic            fetch_done;

    assign cur_y      = slot_y[int'(slot_q)*w_y +: w_y];
    assign cur_id     = slot_id[int'(slot_q)*w_id +: w_id];
    assign dy         = line_q - cur_y;
    // line_q >= cur_y rules out wrap-around; the high bits of dy then bound the row to 0..15.
    assign cur_hit    = slot_en[slot_q] && (line_q >= cur_y) && (dy[w_y-1:4] == '0);
    assign last_slot  = (slot_q == w_s'(n_slots - 1));
    assign fetch_done = rom_ack && !line_start && ((state_q == StReq) || (state_q == StWait));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            slot_q     <= '0;
            line_q     <= '0;
            active_q   <= '0;
            rom_req    <= 1'b0;
            rom_addr   <= '0;
            overrun    <= 1'b0;
            ovr_done_q <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (display_on && (state_q != StIdle) && !ovr_done_q) begin
                overrun    <= 1'b1;
                ovr_done_q <= 1'b1;
            end
            if (line_start) begin
                // Abandons any pending fetch; a late ack then lands in StCheck and is ignored.
                line_q     <= line_y;
                active_q   <= '0;
                slot_q     <= '0;
                state_q    <= StCheck;
                rom_req    <= 1'b0;
                overrun    <= 1'b0;
                ovr_done_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                    end
                    StCheck: begin
                        if (cur_hit) begin
                            state_q  <= StReq;
                            rom_req  <= 1'b1;
                            rom_addr <= {cur_id, dy[3:0]};
                        end else if (last_slot) begin
                            state_q <= StIdle;
                        end else begin
                            slot_q <= slot_q + 1'b1;
                        end
                    end
                    StReq, StWait: begin
                        if (rom_ack) begin
                            active_q[slot_q] <= 1'b1;
                            rom_req          <= 1'b0;
                            if (last_slot) begin
                                state_q <= StIdle;
                            end else begin
                                slot_q  <= slot_q + 1'b1;
                                state_q <= StCheck;
                            end
                        end else begin
                            state_q <= StWait;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Row buffers carry no reset; a slot is only visible once its active flag is set.
    always_ff @(posedge clk) begin
        if (rst && fetch_done) begin
            row_buf[slot_q] <= rom_data;
        end
    end

    // Pixel selection: lowest-index active slot covering x with an opaque nibble wins.
    logic [w_x-1:0] dx;
    logic [3:0]     nib;
    logic           win_hit;
    logic [3:0]     win_color;

    always_comb begin
        win_hit   = 1'b0;
        win_color = 4'd0;
        dx        = '0;
        nib       = 4'd0;
        for (int i = 0; i < int'(n_slots); i++) begin
            dx  = x - slot_x[i*w_x +: w_x];
            // Column c sits at bits [63-4c -: 4], i.e. base 4*(15-c) = {~c, 2'b00}.
            nib = row_buf[i][{~dx[3:0], 2'b00} +: 4];
            if (!win_hit && active_q[i] && (dx[w_x-1:4] == '0) && (nib != 4'd0)) begin
                win_hit   = 1'b1;
                win_color = nib;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_hit   <= 1'b0;
            pix_color <= 4'd0;
        end else begin
            pix_hit   <= display_on && win_hit;
            pix_color <= (display_on && win_hit) ? win_color : 4'd0;
        end
    end

endmodule

// File: tb/tb_sprite_row_scheduler.sv
// tb_sprite_row_scheduler
//   Drives directed scenarios and randomized lines into sprite_row_scheduler. A behavioural
//   model (walk pointer over the slots, one outstanding fetch, per-slot row copies) predicts
//   every output each cycle. A small ROM responder answers requests with a programmable delay
//   and can inject stray acks while no request is pending.

module tb_sprite_row_scheduler;

    localparam int NS  = 4;
    localparam int WX  = 10;
    localparam int WY  = 9;
    localparam int WID = 2;
    localparam int WA  = WID + 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              line_start = 1'b0;
    logic [WY-1:0]     line_y = '0;
    logic [NS-1:0]     slot_en = '0;
    logic [NS*WX-1:0]  slot_x = '0;
    logic [NS*WY-1:0]  slot_y = '0;
    logic [NS*WID-1:0] slot_id = '0;
    logic              rom_req;
    logic [WA-1:0]     rom_addr;
    logic              rom_ack = 1'b0;
    logic [63:0]       rom_data = '0;
    logic              display_on = 1'b0;
    logic [WX-1:0]     x = '0;
    logic [WY-1:0]     y = '0;
    logic              pix_hit;
    logic [3:0]        pix_color;
    logic              overrun;

    sprite_row_scheduler #(
        .n_slots (NS),
        .w_x     (WX),
        .w_y     (WY),
        .w_id    (WID)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .line_start (line_start),
        .line_y     (line_y),
        .slot_en    (slot_en),
        .slot_x     (slot_x),
        .slot_y     (slot_y),
        .slot_id    (slot_id),
        .rom_req    (rom_req),
        .rom_addr   (rom_addr),
        .rom_ack    (rom_ack),
        .rom_data   (rom_data),
        .display_on (display_on),
        .x          (x),
        .y          (y),
        .pix_hit    (pix_hit),
        .pix_color  (pix_color),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // ---------------- ROM responder ----------------
    logic [63:0] rom_mem [64];
    int ack_delay = 0;
    int stray_pct = 0;
    int wait_cnt  = 0;

    always @(posedge clk) begin
        #1;
        rom_ack = 1'b0;
        if (rom_req === 1'b1) begin
            if (wait_cnt >= ack_delay) begin
                rom_ack  = 1'b1;
                rom_data = rom_mem[rom_addr];
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            if (stray_pct != 0 && int'($urandom_range(0, 99)) < stray_pct) begin
                rom_ack  = 1'b1;
                rom_data = {$urandom, $urandom};
            end
        end
    end

    // ---------------- behavioural model ----------------
    bit          m_busy, m_req, m_done, m_hit, m_ovr;
    int          m_ptr, m_line, m_color;
    logic [WA-1:0] m_addr = '0;
    bit [NS-1:0] m_act;
    bit [63:0]   m_rows [NS];

    function automatic int cfg_x(int i);  return int'(slot_x[i*WX +: WX]);    endfunction
    function automatic int cfg_y(int i);  return int'(slot_y[i*WY +: WY]);    endfunction
    function automatic int cfg_id(int i); return int'(slot_id[i*WID +: WID]); endfunction

    task automatic model_advance();
        m_ptr++;
        if (m_ptr >= NS) m_busy = 0;
    endtask

    task automatic model_step();
        bit found;
        int col, dx, nib;
        if (!rst) begin
            m_busy = 0; m_req = 0; m_done = 0; m_ptr = 0; m_act = '0;
            m_addr = '0; m_hit = 0; m_color = 0; m_ovr = 0;
            return;
        end
        found = 0;
        col   = 0;
        for (int i = 0; i < NS; i++) begin
            dx = (int'(x) - cfg_x(i)) & ((1 << WX) - 1);
            if (!found && m_act[i] && dx < 16) begin
                nib = int'((m_rows[i] >> (4 * (15 - dx))) & 64'hF);
                if (nib != 0) begin
                    found = 1;
                    col   = nib;
                end
            end
        end
        m_hit   = display_on && found;
        m_color = m_hit ? col : 0;
        m_ovr   = !line_start && display_on && m_busy && !m_done;
        if (m_ovr) m_done = 1;
        if (line_start) begin
            m_line = int'(line_y);
            m_act  = '0;
            m_busy = 1;
            m_ptr  = 0;
            m_req  = 0;
            m_done = 0;
        end else if (m_busy) begin
            if (m_req) begin
                if (rom_ack) begin
                    m_rows[m_ptr] = rom_data;
                    m_act[m_ptr]  = 1;
                    m_req         = 0;
                    model_advance();
                end
            end else if (slot_en[m_ptr] && m_line >= cfg_y(m_ptr) && m_line - cfg_y(m_ptr) < 16) begin
                m_req  = 1;
                m_addr = WA'(cfg_id(m_ptr) * 16 + (m_line - cfg_y(m_ptr)));
            end else begin
                model_advance();
            end
        end
    endtask

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every clock advance goes through here, so the model is compared on every cycle.
    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
        if (chk_en) begin
            check("rom_req", 64'(rom_req), 64'(m_req));
            if (m_req) check("rom_addr", 64'(rom_addr), 64'(m_addr));
            check("pix_hit", 64'(pix_hit), 64'(m_hit));
            check("pix_color", 64'(pix_color), 64'(m_color));
            check("overrun", 64'(overrun), 64'(m_ovr));
        end
    endtask

    task automatic set_slot(int i, bit en, int sx, int sy, int id);
        slot_en[i]             = en;
        slot_x[i*WX +: WX]     = WX'(sx);
        slot_y[i*WY +: WY]     = WY'(sy);
        slot_id[i*WID +: WID]  = WID'(id);
    endtask

    task automatic clear_slots();
        for (int i = 0; i < NS; i++) set_slot(i, 0, 0, 0, 0);
    endtask

    task automatic start_line(int ly);
        line_y     = WY'(ly);
        y          = WY'(ly);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    int edge_ly   [5] = '{99, 116, 100, 115, 4};
    int edge_sy   [5] = '{100, 100, 100, 100, 500};
    bit edge_seen [5] = '{0, 0, 1, 1, 0};
    int edge_addr [5] = '{0, 0, 'h10, 'h1F, 0};

    initial begin
        bit seen;
        int addr, pulses, ly, len;
        logic ovr_pix;

        for (int a = 0; a < 64; a++) rom_mem[a] = {$urandom, $urandom} & {$urandom, $urandom};

        // Reset state
        rst = 1'b0;
        tick();
        chk_en = 1;
        tick();
        check("reset_rom_req", 64'(rom_req), 0);
        check("reset_rom_addr", 64'(rom_addr), 0);
        check("reset_pix_hit", 64'(pix_hit), 0);
        check("reset_overrun", 64'(overrun), 0);
        rst = 1'b1;
        tick();

        // Single hit: slot0 y=100 x=200 id=1, line 105 -> addr 0x15, ack after 3 cycles
        clear_slots();
        set_slot(0, 1, 200, 100, 1);
        rom_mem[6'h15] = 64'hF000_0000_0000_000C;
        ack_delay = 3;
        start_line(105);
        tick();
        check("single_req", 64'(rom_req), 1);
        check("single_addr", 64'(rom_addr), 64'h15);
        check("model_addr", 64'(m_addr), 64'h15);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("single_addr_held", 64'(rom_addr), 64'h15);
        end
        tick();
        check("single_req_drop", 64'(rom_req), 0);
        repeat (5) tick();
        display_on = 1'b1;
        x = WX'(200); tick();
        check("single_x200_hit", 64'(pix_hit), 1);
        check("single_x200_color", 64'(pix_color), 64'hF);
        x = WX'(215); tick();
        check("single_x215_color", 64'(pix_color), 64'hC);
        x = WX'(201); tick();
        check("single_x201_hit", 64'(pix_hit), 0);
        x = WX'(216); tick();
        check("single_x216_hit", 64'(pix_hit), 0);
        display_on = 1'b0;
        tick();

        // Priority between overlapping slots at x=300
        clear_slots();
        set_slot(0, 1, 300, 100, 0);
        set_slot(1, 1, 300, 100, 2);
        rom_mem[0]  = 64'h3000_0000_0000_0000;
        rom_mem[32] = 64'h7000_0000_0000_0000;
        ack_delay = 0;
        x = WX'(300);
        start_line(100);
        repeat (12) tick();
        display_on = 1'b1;
        tick();
        check("prio_slot0_color", 64'(pix_color), 64'h3);
        display_on = 1'b0;
        rom_mem[0] = 64'h0;
        start_line(100);
        repeat (12) tick();
        display_on = 1'b1;
        tick();
        check("prio_slot1_color", 64'(pix_color), 64'h7);
        display_on = 1'b0;
        tick();

        // Range edges, including no wrap-around for slot y=500 on line 4
        for (int k = 0; k < 5; k++) begin
            clear_slots();
            set_slot(0, 1, 0, edge_sy[k], 1);
            start_line(edge_ly[k]);
            seen = 0;
            addr = 0;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (rom_req === 1'b1 && !seen) begin
                    seen = 1;
                    addr = int'(rom_addr);
                end
            end
            check($sformatf("edge_req_line%0d", edge_ly[k]), 64'(seen), 64'(edge_seen[k]));
            if (edge_seen[k]) check($sformatf("edge_addr_line%0d", edge_ly[k]), 64'(addr),
                                    64'(edge_addr[k]));
        end

        // Overrun: four hits, ack latency 50, display on 100 cycles after line_start
        clear_slots();
        for (int i = 0; i < NS; i++) begin
            set_slot(i, 1, 10 + 20 * i, 100, i);
            rom_mem[16 * i] = 64'(i + 1) << 60;
        end
        ack_delay = 50;
        x = WX'(50);
        start_line(100);
        repeat (100) tick();
        display_on = 1'b1;
        pulses  = 0;
        ovr_pix = 1'b1;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (overrun === 1'b1) begin
                pulses++;
                if (pulses == 1) ovr_pix = pix_hit;
            end
        end
        check("ovr_pulses", 64'(pulses), 1);
        check("ovr_slot2_hidden", 64'(ovr_pix), 0);
        check("ovr_slot2_late_hit", 64'(pix_hit), 1);
        check("ovr_slot2_late_color", 64'(pix_color), 3);
        display_on = 1'b0;
        tick();

        // Abort: line_start while waiting, stray ack during the rescan
        clear_slots();
        set_slot(0, 1, 0, 100, 1);
        ack_delay = 1000;
        start_line(105);
        repeat (5) tick();
        check("abort_waiting", 64'(rom_req), 1);
        stray_pct = 100;
        start_line(106);
        check("abort_req_low", 64'(rom_req), 0);
        ack_delay = 0;
        tick();
        check("abort_rescan_req", 64'(rom_req), 1);
        check("abort_rescan_addr", 64'(rom_addr), 64'h16);
        stray_pct = 0;
        repeat (6) tick();

        // Reset mid-wait
        ack_delay = 1000;
        start_line(105);
        repeat (5) tick();
        rst = 1'b0;
        tick();
        check("rst_rom_req", 64'(rom_req), 0);
        check("rst_rom_addr", 64'(rom_addr), 0);
        check("rst_pix_hit", 64'(pix_hit), 0);
        check("rst_pix_color", 64'(pix_color), 0);
        check("rst_overrun", 64'(overrun), 0);
        rst = 1'b1;
        stray_pct = 100;
        repeat (4) tick();
        stray_pct = 0;
        ack_delay = 0;

        // Randomized lines
        for (int a = 0; a < 64; a++) rom_mem[a] = {$urandom, $urandom} & {$urandom, $urandom};
        for (int ln = 0; ln < 60; ln++) begin
            ly = int'($urandom_range(0, 511));
            for (int i = 0; i < NS; i++)
                set_slot(i, $urandom_range(0, 3) != 0, int'($urandom_range(100, 170)),
                         (ly - int'($urandom_range(0, 20))) & 511, int'($urandom_range(0, 3)));
            ack_delay = int'($urandom_range(0, 4));
            stray_pct = ($urandom_range(0, 1) != 0) ? 25 : 0;
            start_line(ly);
            len = int'($urandom_range(3, 40));
            for (int c = 0; c < len; c++) begin
                display_on = $urandom_range(0, 2) != 0;
                x = WX'($urandom_range(95, 190));
                if ($urandom_range(0, 30) == 0)
                    set_slot(int'($urandom_range(0, NS - 1)), 1, int'($urandom_range(100, 170)),
                             (ly - int'($urandom_range(0, 20))) & 511,
                             int'($urandom_range(0, 3)));
                rst = ($urandom_range(0, 200) != 0);
                tick();
                rst = 1'b1;
            end
        end
        display_on = 1'b0;
        stray_pct  = 0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sprite_row_scheduler.md
SPRITE_ROW_SCHEDULER -- requirements
Module: sprite_row_scheduler

Interface
REQ-001 The block SHALL have parameter n_slots, default 4, meaning the number of sprite slots (1..8).
REQ-002 The block SHALL have parameter w_x, default 10, meaning the screen X coordinate width.
REQ-003 The block SHALL have parameter w_y, default 9, meaning the screen Y coordinate width.
REQ-004 The block SHALL have parameter w_id, default 2, meaning the sprite image index width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low (rst = 0 resets).
REQ-007 The block SHALL have port line_start, input, 1 bit: one-cycle pulse at the start of horizontal blanking.
REQ-008 The block SHALL have port line_y, input, w_y bits: the screen line to prepare, valid with line_start.
REQ-009 The block SHALL have ports slot_en [n_slots], slot_x [n_slots*w_x], slot_y [n_slots*w_y] and slot_id [n_slots*w_id], inputs: live per-slot config (top-left corner and image).
REQ-010 The block SHALL have ports rom_req (output, 1), rom_addr (output, w_id+4), rom_ack (input, 1) and rom_data (input, 64): the shared sprite-ROM read port.
REQ-011 The block SHALL have ports display_on (input, 1), x (input, w_x) and y (input, w_y): the current pixel position.
REQ-012 The block SHALL have ports pix_hit (output, 1), pix_color (output, 4) and overrun (output, 1).

Function
REQ-013 Sprites SHALL be 16x16 pixels; a ROM row is 64 bits; pixel column c is at bits [63-4c : 60-4c]; nibble 0 is transparent.
REQ-014 The FSM SHALL have states IDLE, CHECK, REQ and WAIT, with slot index s held in a register.
REQ-015 line_start in any state SHALL do three things next cycle: latch line_y, clear all slot active flags, and enter CHECK with s=0.
REQ-016 In CHECK, slot s SHALL hit if slot_en[s]=1, line_y >= slot_y[s] and (line_y - slot_y[s]) < 16; the compare SHALL be unsigned with no wrap-around.
REQ-017 On a CHECK hit the FSM SHALL go to REQ.
REQ-018 On a CHECK miss the FSM SHALL take s+1 and stay in CHECK, or go to IDLE if s = n_slots-1; this costs one cycle per slot.
REQ-019 In REQ and WAIT, rom_req SHALL be 1 and rom_addr SHALL equal {slot_id[s], row[3:0]}, both held stable until rom_ack.
REQ-020 slot_id SHALL be sampled into a register on entry to REQ.
REQ-021 In REQ or WAIT with rom_ack=1, the block SHALL store rom_data into row buffer s, set active[s], and advance exactly as a CHECK miss does.
REQ-022 With rom_ack=0 in REQ the FSM SHALL go to WAIT; in WAIT with rom_ack=0 it SHALL remain in WAIT.
REQ-023 rom_ack while rom_req=0 SHALL be ignored; rom_req SHALL be 0 in IDLE and CHECK.
REQ-024 The ROM latency SHALL be unbounded, with exactly one outstanding request at a time.
REQ-025 Pixel path (1-cycle latency): for the current x, the winning slot is the lowest-index slot with active=1, (x - slot_x) in 0..15 (unsigned), and a non-zero nibble.
REQ-026 If display_on=1 and a winning slot exists, pix_hit SHALL be 1 and pix_color SHALL be that slot's nibble; otherwise pix_hit=0 and pix_color=0.
REQ-027 Both pixel outputs SHALL be registered.
REQ-028 If display_on=1 while the FSM is not in IDLE, overrun SHALL pulse for exactly one cycle, once per line.
REQ-029 After an overrun the scan SHALL continue; slots not yet fetched SHALL stay invisible until their fetch completes.
REQ-030 A line_start during REQ or WAIT SHALL abandon the pending request: rom_req drops for at least the one cycle spent re-entering CHECK, and a late rom_ack is ignored.
REQ-031 Config changes during a scan SHALL affect only slots not yet examined.

Reset
REQ-032 While rst=0 at a clock edge, the block SHALL set: state=IDLE, s=0, all active flags=0, rom_req=0, rom_addr=0, pix_hit=0, pix_color=0, overrun=0.
REQ-033 Row buffer contents SHALL need no reset.
REQ-034 Reset mid-request SHALL drop rom_req the next cycle; a following rom_ack SHALL be ignored.

Verification
REQ-035 Single hit: slot0 enabled with y=100, x=200, id=1; line_start line_y=105 -> rom_addr=0x15 held; ack after 3 cycles with row pattern 0xF000_..._000C -> at x=200 pix_hit=1, color=0xF one cycle later; at x=215 color=0xC; at x=201 and x=216 pix_hit=0.
REQ-036 Priority: slots 0 and 1 overlap at x=300 with nibbles 0x3 (slot0) and 0x7 (slot1) -> color 0x3; with slot0's nibble 0 -> color 0x7.
REQ-037 Range edges with slot y=100: line_y 99 and 116 -> no request; line_y 100 -> row 0; line_y 115 -> row 15; slot y=500, line_y=4 -> no hit (no wrap).
REQ-038 Overrun: 4 hits with ack latency 50 and display_on raised 100 cycles after line_start -> exactly one overrun pulse; slots 2 and 3 become visible only after their acks.
REQ-039 Abort and reset: line_start in WAIT -> rom_req low for 1 cycle, then rescan from slot 0, and a stale ack is ignored; rst=0 for one edge mid-WAIT -> all outputs 0 next cycle.
